// File: rtl/ahb_slave_pkg.sv
// Shared types and constants for the AHB-Lite slave control pipe of the USB
// endpoint buffer interface.
package ahb_slave_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    ERR1  = 3'd3,
    ERR2  = 3'd4
  } ctrl_state_t;

  typedef enum logic [2:0] {
    REG_NONE    = 3'd0,
    REG_STATUS  = 3'd1,
    REG_ERRCODE = 3'd2,
    REG_OCC     = 3'd3,
    REG_TXSIZE  = 3'd4
  } reg_sel_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  // Register offsets relative to the end of the data-buffer window.
  localparam int unsigned OFF_STATUS  = 0;
  localparam int unsigned OFF_ERRCODE = 2;
  localparam int unsigned OFF_OCC     = 4;
  localparam int unsigned OFF_TXSIZE  = 8;

  // Only NONSEQ and SEQ carry a real transfer.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational address-phase decoder: classifies an access as buffer or
// register, and flags size, alignment and access-permission errors.
module ahb_addr_decode
  import ahb_slave_pkg::*;
#(
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned BUF_BYTES = 64,
  parameter int unsigned MAX_HSIZE = 2
) (
  input  logic [ADDR_W-1:0] haddr_i,
  input  logic [2:0]        hsize_i,
  input  logic              hwrite_i,
  output logic              buf_access_o,
  output reg_sel_t          reg_sel_o,
  output logic              legal_o
);

  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(BUF_BYTES + OFF_STATUS);
  localparam logic [ADDR_W-1:0] A_ERRCODE = ADDR_W'(BUF_BYTES + OFF_ERRCODE);
  localparam logic [ADDR_W-1:0] A_OCC     = ADDR_W'(BUF_BYTES + OFF_OCC);
  localparam logic [ADDR_W-1:0] A_TXSIZE  = ADDR_W'(BUF_BYTES + OFF_TXSIZE);

  logic aligned;
  logic size_ok;
  logic reg_ok;

  // Decode window, register index and legality of the presented access.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a value held and no latch is inferred.
    aligned      = 1'b1;
    size_ok      = (hsize_i <= 3'(MAX_HSIZE));
    buf_access_o = (haddr_i < ADDR_W'(BUF_BYTES));
    reg_sel_o    = REG_NONE;
    reg_ok       = 1'b0;

    // Low hsize address bits must be zero for a naturally aligned access.
    for (int i = 0; i < int'(ADDR_W); i++) begin
      if ((i < int'(hsize_i)) && haddr_i[i]) aligned = 1'b0;
    end

    case (haddr_i)
      A_STATUS: begin
        reg_sel_o = REG_STATUS;
        reg_ok    = !hwrite_i && (hsize_i <= 3'd1);
      end
      A_ERRCODE: begin
        reg_sel_o = REG_ERRCODE;
        reg_ok    = !hwrite_i && (hsize_i <= 3'd1);
      end
      A_OCC: begin
        reg_sel_o = REG_OCC;
        reg_ok    = !hwrite_i && (hsize_i == 3'd0);
      end
      A_TXSIZE: begin
        reg_sel_o = REG_TXSIZE;
        reg_ok    = (hsize_i == 3'd0);
      end
      default: ;
    endcase

    legal_o = size_ok && aligned && (buf_access_o || reg_ok);
  end

endmodule

// File: rtl/ahb_slave_ctrl_pipe.sv
// AHB-Lite slave control FSM for the USB endpoint buffer: registers the
// address phase, drives buffer strobes in the data phase with wait states and
// a timeout, and produces the two-cycle ERROR response.
module ahb_slave_ctrl_pipe
  import ahb_slave_pkg::*;
#(
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned BUF_BYTES = 64,
  parameter int unsigned MAX_HSIZE = 2,
  parameter int unsigned MAX_WAIT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic              hwrite,
  input  logic              hsel,
  input  logic              buf_ready,
  output ctrl_state_t       state,
  output logic              hready,
  output logic              hresp,
  output logic              store_tx_data,
  output logic              get_rx_data,
  output logic [ADDR_W-1:0] data_addr,
  output logic [1:0]        data_size,
  output reg_sel_t          reg_sel,
  output logic              tx_packet_size_changed
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  ctrl_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic [1:0]        data_size_q, data_size_d;
  reg_sel_t          reg_sel_q, reg_sel_d;
  logic              data_buf_q, data_buf_d;

  logic              dec_buf;
  reg_sel_t          dec_reg_sel;
  logic              dec_legal;
  logic              accept;

  ahb_addr_decode #(
    .ADDR_W   (ADDR_W),
    .BUF_BYTES(BUF_BYTES),
    .MAX_HSIZE(MAX_HSIZE)
  ) u_decode (
    .haddr_i     (haddr),
    .hsize_i     (hsize),
    .hwrite_i    (hwrite),
    .buf_access_o(dec_buf),
    .reg_sel_o   (dec_reg_sel),
    .legal_o     (dec_legal)
  );

  // Data-phase outputs, wait counting and next-state / address-phase capture.
  always_comb begin
    state_d                = state_q;
    wait_cnt_d             = wait_cnt_q;
    data_addr_d            = data_addr_q;
    data_size_d            = data_size_q;
    reg_sel_d              = reg_sel_q;
    data_buf_d             = data_buf_q;
    hready                 = 1'b1;
    hresp                  = 1'b0;
    store_tx_data          = 1'b0;
    get_rx_data            = 1'b0;
    tx_packet_size_changed = 1'b0;
    accept                 = 1'b0;

    case (state_q)
      WRITE, READ: begin
        if (data_buf_q) begin
          if (!buf_ready && (wait_cnt_q == WAIT_W'(MAX_WAIT))) begin
            // Timeout: strobe withdrawn, error response follows.
            hready     = 1'b0;
            wait_cnt_d = '0;
            state_d    = ERR1;
          end else begin
            store_tx_data = (state_q == WRITE);
            get_rx_data   = (state_q == READ);
            hready        = buf_ready;
            wait_cnt_d    = buf_ready ? '0 : wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          // Register accesses always finish in one data-phase cycle.
          tx_packet_size_changed = (state_q == WRITE) && (reg_sel_q == REG_TXSIZE);
        end
      end
      ERR1: begin
        hready  = 1'b0;
        hresp   = 1'b1;
        state_d = ERR2;
      end
      ERR2: begin
        hresp = 1'b1;
      end
      default: ;
    endcase

    // Any cycle that ends a data phase may take the next address phase.
    if (hready) begin
      accept = hsel && htrans_active(htrans);
      if (accept) begin
        data_addr_d = haddr;
        data_size_d = hsize[1:0];
        reg_sel_d   = dec_reg_sel;
        data_buf_d  = dec_buf;
        if (!dec_legal)  state_d = ERR1;
        else if (hwrite) state_d = WRITE;
        else             state_d = READ;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // State and data-phase registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      data_addr_q <= '0;
      data_size_q <= '0;
      reg_sel_q   <= REG_NONE;
      data_buf_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      data_addr_q <= data_addr_d;
      data_size_q <= data_size_d;
      reg_sel_q   <= reg_sel_d;
      data_buf_q  <= data_buf_d;
    end
  end

  assign state     = state_q;
  assign data_addr = data_addr_q;
  assign data_size = data_size_q;
  assign reg_sel   = reg_sel_q;

endmodule

// File: tb/tb_ahb_slave_ctrl_pipe.sv
// Scoreboard bench for ahb_slave_ctrl_pipe: each stimulus cycle pushes the
// hand-computed expected outputs; a negedge monitor pops and compares.
module tb_ahb_slave_ctrl_pipe;
  import ahb_slave_pkg::*;

  localparam int unsigned ADDR_W = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] haddr = '0;
  logic [1:0]        htrans = HTRANS_IDLE;
  logic [2:0]        hsize = '0;
  logic              hwrite = 1'b0;
  logic              hsel = 1'b1;
  logic              buf_ready = 1'b0;
  ctrl_state_t       state;
  logic              hready, hresp, store_tx_data, get_rx_data;
  logic [ADDR_W-1:0] data_addr;
  logic [1:0]        data_size;
  reg_sel_t          reg_sel;
  logic              tx_packet_size_changed;

  ahb_slave_ctrl_pipe #(
    .ADDR_W(ADDR_W), .BUF_BYTES(64), .MAX_HSIZE(2), .MAX_WAIT(15)
  ) dut (
    .clk(clk), .rst(rst), .haddr(haddr), .htrans(htrans), .hsize(hsize),
    .hwrite(hwrite), .hsel(hsel), .buf_ready(buf_ready), .state(state),
    .hready(hready), .hresp(hresp), .store_tx_data(store_tx_data),
    .get_rx_data(get_rx_data), .data_addr(data_addr), .data_size(data_size),
    .reg_sel(reg_sel), .tx_packet_size_changed(tx_packet_size_changed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    ctrl_state_t       st;
    logic              rdy;
    logic              rsp;
    logic              ws;
    logic              rs;
    logic              pulse;
    logic              chk_d;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    reg_sel_t          rsel;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_cyc    = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
  endfunction

  // Expected control outputs only (data-phase registers not compared).
  function automatic exp_t ex(input ctrl_state_t st, input logic rdy, input logic rsp,
                              input logic ws, input logic rs, input logic p);
    exp_t e;
    e = '0;
    e.st = st; e.rdy = rdy; e.rsp = rsp; e.ws = ws; e.rs = rs; e.pulse = p;
    e.rsel = REG_NONE;
    return e;
  endfunction

  // Expected control outputs plus registered data-phase address/size/reg_sel.
  function automatic exp_t exd(input ctrl_state_t st, input logic rdy, input logic ws,
                               input logic rs, input logic p, input logic [ADDR_W-1:0] a,
                               input logic [1:0] z, input reg_sel_t r);
    exp_t e;
    e = ex(st, rdy, 1'b0, ws, rs, p);
    e.chk_d = 1'b1; e.addr = a; e.size = z; e.rsel = r;
    return e;
  endfunction

  function automatic exp_t e_idle();
    return ex(IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // One bus cycle: drive inputs just after the edge and queue the expectation.
  task automatic cyc(input logic [1:0] tr, input logic [ADDR_W-1:0] a, input logic [2:0] z,
                     input logic w, input logic br, input logic r, input exp_t e);
    @(posedge clk);
    #1;
    htrans = tr; haddr = a; hsize = z; hwrite = w; buf_ready = br; rst = r;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT against the queued expectation mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_cyc++;
      check($sformatf("ctl{st,rdy,rsp,wr,rd,pulse}@cyc%0d", n_cyc),
            32'({state, hready, hresp, store_tx_data, get_rx_data, tx_packet_size_changed}),
            32'({mon_e.st, mon_e.rdy, mon_e.rsp, mon_e.ws, mon_e.rs, mon_e.pulse}));
      if (mon_e.chk_d)
        check($sformatf("dat{addr,size,reg}@cyc%0d", n_cyc),
              32'({data_addr, data_size, reg_sel}),
              32'({mon_e.addr, mon_e.size, mon_e.rsel}));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values.
    cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b0, 1'b1, exd(IDLE, 1, 0, 0, 0, 7'h00, 2'd0, REG_NONE));
    cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0, e_idle());

    // Word write to 0x04, buffer ready at once.
    cyc(HTRANS_NONSEQ, 7'h04, 3'd2, 1'b1, 1'b1, 1'b0, e_idle());
    cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b1, 1'b0, exd(WRITE, 1, 1, 0, 0, 7'h04, 2'd2, REG_NONE));
    cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b1, 1'b0, e_idle());

    // Byte read of 0x10 with 3 wait states, then pipelined reads 0x14, 0x18.
    cyc(HTRANS_NONSEQ, 7'h10, 3'd0, 1'b0, 1'b0, 1'b0, e_idle());
    for (int i = 0; i < 3; i++)
      cyc(HTRANS_NONSEQ, 7'h14, 3'd0, 1'b0, 1'b0, 1'b0, exd(READ, 0, 0, 1, 0, 7'h10, 2'd0, REG_NONE));
    cyc(HTRANS_NONSEQ, 7'h14, 3'd0, 1'b0, 1'b1, 1'b0, exd(READ, 1, 0, 1, 0, 7'h10, 2'd0, REG_NONE));
    cyc(HTRANS_NONSEQ, 7'h18, 3'd0, 1'b0, 1'b1, 1'b0, exd(READ, 1, 0, 1, 0, 7'h14, 2'd0, REG_NONE));
    cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b1, 1'b0, exd(READ, 1, 0, 1, 0, 7'h18, 2'd0, REG_NONE));
    cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b1, 1'b0, e_idle());

    // Word read of 0x00 that never gets buf_ready: 15 stalls, timeout, error.
    cyc(HTRANS_NONSEQ, 7'h00, 3'd2, 1'b0, 1'b0, 1'b0, e_idle());
    for (int i = 0; i < 15; i++)
      cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0, exd(READ, 0, 0, 1, 0, 7'h00, 2'd2, REG_NONE));
    cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0, exd(READ, 0, 0, 0, 0, 7'h00, 2'd2, REG_NONE));
    cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0, ex(ERR1, 0, 1, 0, 0, 0));
    cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0, ex(ERR2, 1, 1, 0, 0, 0));
    cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0, e_idle());

    // Misaligned halfword, oversize, write to STATUS: back-to-back errors via
    // ERR2, then a legal STATUS halfword read accepted in ERR2.
    cyc(HTRANS_NONSEQ, 7'h03, 3'd1, 1'b1, 1'b1, 1'b0, e_idle());
    cyc(HTRANS_NONSEQ, 7'h08, 3'd3, 1'b1, 1'b1, 1'b0, ex(ERR1, 0, 1, 0, 0, 0));
    cyc(HTRANS_NONSEQ, 7'h08, 3'd3, 1'b1, 1'b1, 1'b0, ex(ERR2, 1, 1, 0, 0, 0));
    cyc(HTRANS_NONSEQ, 7'h40, 3'd0, 1'b1, 1'b1, 1'b0, ex(ERR1, 0, 1, 0, 0, 0));
    cyc(HTRANS_NONSEQ, 7'h40, 3'd0, 1'b1, 1'b1, 1'b0, ex(ERR2, 1, 1, 0, 0, 0));
    cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b1, 1'b0, ex(ERR1, 0, 1, 0, 0, 0));
    cyc(HTRANS_NONSEQ, 7'h40, 3'd1, 1'b0, 1'b1, 1'b0, ex(ERR2, 1, 1, 0, 0, 0));
    cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b1, 1'b0, exd(READ, 1, 0, 0, 0, 7'h40, 2'd1, REG_STATUS));
    cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b1, 1'b0, e_idle());

    // TX_PKT_SIZE byte write pulses once; BUSY at the same address does not.
    cyc(HTRANS_NONSEQ, 7'h48, 3'd0, 1'b1, 1'b1, 1'b0, e_idle());
    cyc(HTRANS_BUSY, 7'h48, 3'd0, 1'b1, 1'b1, 1'b0, exd(WRITE, 1, 0, 0, 1, 7'h48, 2'd0, REG_TXSIZE));
    cyc(HTRANS_BUSY, 7'h48, 3'd0, 1'b1, 1'b1, 1'b0, e_idle());
    cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b1, 1'b0, e_idle());

    // ERRCODE halfword and OCCUPANCY byte reads, then an oversize OCCUPANCY read.
    cyc(HTRANS_NONSEQ, 7'h42, 3'd1, 1'b0, 1'b1, 1'b0, e_idle());
    cyc(HTRANS_NONSEQ, 7'h44, 3'd0, 1'b0, 1'b1, 1'b0, exd(READ, 1, 0, 0, 0, 7'h42, 2'd1, REG_ERRCODE));
    cyc(HTRANS_NONSEQ, 7'h44, 3'd1, 1'b0, 1'b1, 1'b0, exd(READ, 1, 0, 0, 0, 7'h44, 2'd0, REG_OCC));
    cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b1, 1'b0, ex(ERR1, 0, 1, 0, 0, 0));
    cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b1, 1'b0, ex(ERR2, 1, 1, 0, 0, 0));
    cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b1, 1'b0, e_idle());

    // Unselected slave ignores a NONSEQ.
    hsel = 1'b0;
    cyc(HTRANS_NONSEQ, 7'h04, 3'd2, 1'b1, 1'b1, 1'b0, e_idle());
    cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b1, 1'b0, e_idle());
    hsel = 1'b1;

    // Reset while stalled in READ aborts the transfer.
    cyc(HTRANS_NONSEQ, 7'h20, 3'd2, 1'b0, 1'b0, 1'b0, e_idle());
    cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0, exd(READ, 0, 0, 1, 0, 7'h20, 2'd2, REG_NONE));
    cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b0, 1'b1, exd(READ, 0, 0, 1, 0, 7'h20, 2'd2, REG_NONE));
    cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b0, 1'b0, exd(IDLE, 1, 0, 0, 0, 7'h00, 2'd0, REG_NONE));
    check("rst_wait_cnt", 32'(dut.wait_cnt_q), 32'd0);

    // Normal operation resumes after reset.
    cyc(HTRANS_NONSEQ, 7'h3C, 3'd2, 1'b0, 1'b1, 1'b0, e_idle());
    cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b1, 1'b0, exd(READ, 1, 0, 1, 0, 7'h3C, 2'd2, REG_NONE));
    cyc(HTRANS_IDLE, 7'h00, 3'd0, 1'b0, 1'b1, 1'b0, e_idle());

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb_slave_ctrl_pipe.md
Name: ahb_slave_ctrl_pipe

Overview:
Parametrised AHB-Lite slave control FSM for the USB endpoint buffer interface. It generalises buffer size, address width and maximum transfer size. It registers the address phase and issues buffer strobes in the true data phase. It adds wait-state insertion with a timeout, alignment checking, and the AHB-compliant two-cycle ERROR response. It sits between the AHB-Lite bus and the data buffer / register file of the USB module.

Parameters:
ADDR_W, 7, haddr width in bits; must satisfy 2**ADDR_W >= BUF_BYTES + 16.
BUF_BYTES, 64, data-buffer window size in bytes; power of 2; buffer occupies addresses 0..BUF_BYTES-1.
MAX_HSIZE, 2, largest legal hsize (2 = 32-bit word).
MAX_WAIT, 15, maximum wait states per buffer access before a timeout ERROR; must be >= 1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
haddr  in  ADDR_W  AHB address
htrans  in  2  AHB transfer type (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ)
hsize  in  3  AHB transfer size
hwrite  in  1  AHB write flag
hsel  in  1  slave select
buf_ready  in  1  buffer can complete the current strobe this cycle
state  out  3  current FSM state (ctrl_state_t)
hready  out  1  AHB ready out
hresp  out  1  AHB response (1 = ERROR)
store_tx_data  out  1  buffer write strobe (data phase)
get_rx_data  out  1  buffer read strobe (data phase)
data_addr  out  ADDR_W  registered data-phase address
data_size  out  2  registered data-phase hsize[1:0]
reg_sel  out  3  registered register index for non-buffer accesses (reg_sel_t)
tx_packet_size_changed  out  1  one-cycle pulse in the data phase of a TX_PKT_SIZE write

Behaviour:
- Reset: state=IDLE, hready=1, hresp=0, all strobes and pulses 0, data_addr=0, data_size=0, reg_sel=REG_NONE, wait_cnt=0. Reset mid-transfer aborts the transfer immediately; no strobe fires in the cycle after reset.
- Address phase is accepted when hsel && hready && htrans[1]. IDLE and BUSY transfers are not accepted: the FSM goes to IDLE with an OKAY response.
- Decode of an accepted address phase, with offsets relative to B = BUF_BYTES:
  - Error if hsize > MAX_HSIZE, or haddr % (1<<hsize) != 0.
  - Buffer window 0..B-1: R/W, any legal size.
  - STATUS B+0 and ERRCODE B+2: read-only, size <= 1.
  - OCCUPANCY B+4: read-only, size 0.
  - TX_PKT_SIZE B+8: R/W, size 0.
  - Anything else is an error, including writes to read-only registers.
- States: IDLE, WRITE, READ, ERR1, ERR2. The next state is registered.
- Legal buffer access: state=WRITE or READ; store_tx_data or get_rx_data is 1 in the data phase. The handshake completes on the cycle where strobe && buf_ready:
  - hready = buf_ready while the strobe is high.
  - The strobe stays high, and data_addr and data_size stay stable, until completion.
- Register access: completes in a single data-phase cycle with hready=1. tx_packet_size_changed pulses in that cycle.
- Wait timeout: wait_cnt increments on each stalled cycle. When wait_cnt == MAX_WAIT and buf_ready is still 0:
  - The strobe drops and the FSM goes to ERR1.
  - ERRCODE source reg_sel is unchanged.
  - wait_cnt clears on completion, error, or reset.
- Error response, cycle-exact:
  - ERR1: hresp=1, hready=0, no address phase accepted.
  - ERR2: hresp=1, hready=1.
  - An address phase presented during ERR2 is accepted and decoded normally, so back-to-back works.
- Pipelining: any cycle with hready=1 (IDLE, completing data phase, ERR2) may accept a new address phase. The FSM then moves directly to that transfer's data state with no idle bubble.
- hsize bit 2 is used for decode only; data_size carries bits [1:0].

Decomposition:
- Package ahb_slave_pkg holds:
  - ctrl_state_t (IDLE, WRITE, READ, ERR1, ERR2).
  - reg_sel_t (REG_NONE, REG_STATUS, REG_ERRCODE, REG_OCC, REG_TXSIZE).
  - HTRANS_* constants.
  - Register offset localparams (OFF_STATUS=0, OFF_ERRCODE=2, OFF_OCC=4, OFF_TXSIZE=8).
- One sub-module, ahb_addr_decode: purely combinational, mapping haddr/hsize/hwrite to {buf_access, reg_sel, legal}. It is verified standalone.

Test Plan:
- Word write to 0x04, buf_ready=1 -> next cycle store_tx_data=1, data_addr=0x04, data_size=2, hready=1, hresp=0; back to IDLE the cycle after.
- Byte read of 0x10 with buf_ready=0 for 3 cycles -> get_rx_data=1 and hready=0 for 3 cycles, completes on the 4th; two back-to-back NONSEQ reads show no bubble.
- Read of 0x00 with buf_ready held 0, MAX_WAIT=15 -> 15 stall cycles, then ERR1 (hresp=1, hready=0), then ERR2 (hresp=1, hready=1), then IDLE.
- Halfword write to 0x03 (misaligned), hsize=3, and a write to STATUS 0x40 -> each gives ERR1 then ERR2 with no strobe asserted.
- Byte write to 0x48 -> tx_packet_size_changed=1 for exactly 1 cycle in the data phase, reg_sel=REG_TXSIZE; htrans=BUSY at 0x48 -> no pulse, OKAY.
- rst asserted while stalled in READ -> next cycle state=IDLE, strobes=0, hready=1, wait_cnt=0.
